// File: rtl/clk_div_tdm.sv
// clk_div_tdm: programmable synchronous clock divider with a time-division output mux.
//
// Produces a registered divided clock (clk_out) at clk / N_eff and registered single-cycle
// edge strobes. On each selected clk_out edge, the next of CHANNELS input words is loaded
// round-robin onto out. The divided clock is a data signal only; downstream logic should
// use rise_tick / fall_tick / out_valid as clock enables.
//
// Ports:
//   clk        in   system clock, all state changes on its rising edge
//   reset      in   synchronous active-high reset
//   enable     in   advance the divider when high, freeze all state when low
//   div_ratio  in   requested ratio N (0 and 1 behave as 2), sampled at period start
//   data_in    in   packed channels, channel k = data_in[k*DATA_W +: DATA_W]
//   clk_out    out  registered divided clock
//   rise_tick  out  pulse in the cycle clk_out has just become 1
//   fall_tick  out  pulse in the cycle clk_out has just become 0
//   out        out  registered selected channel word
//   chan_sel   out  index of the channel currently on out
//   out_valid  out  pulse in the cycle out has just been reloaded
module clk_div_tdm #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned DIV_W     = 8,
  parameter bit          EDGE_MODE = 1'b0,
  localparam int unsigned SelW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [DIV_W-1:0]           div_ratio,
  input  logic [CHANNELS*DATA_W-1:0] data_in,
  output logic                       clk_out,
  output logic                       rise_tick,
  output logic                       fall_tick,
  output logic [DATA_W-1:0]          out,
  output logic [SelW-1:0]            chan_sel,
  output logic                       out_valid
);

  localparam logic [SelW-1:0] LastChan = SelW'(CHANNELS - 1);

  // Divider state
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] n_eff_q, n_eff_d;
  logic [DIV_W-1:0] ratio_eff;
  logic [DIV_W:0]   half;     // H = ceil(N_eff/2), one bit wider so N_eff+1 cannot wrap
  logic [DIV_W:0]   cnt_inc;
  logic             wrap;
  logic             clk_out_d;
  logic             rise_d, fall_d;

  // Channel mux state
  logic [SelW-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] chan_data;
  logic              load;

  assign ratio_eff = (div_ratio < DIV_W'(2)) ? DIV_W'(2) : div_ratio;
  assign half      = ({1'b0, n_eff_q} + (DIV_W + 1)'(1)) >> 1;
  assign cnt_inc   = {1'b0, cnt_q} + (DIV_W + 1)'(1);
  assign wrap      = (cnt_q == (n_eff_q - DIV_W'(1)));

  // Next-state for counter, divided clock and the latched ratio. The ratio is only
  // re-sampled at the wrap, so a ratio change always takes effect on a period boundary.
  always_comb begin
    cnt_d     = cnt_q;
    n_eff_d   = n_eff_q;
    clk_out_d = clk_out;
    if (enable) begin
      if (wrap) begin
        cnt_d     = '0;
        clk_out_d = 1'b1;
        n_eff_d   = ratio_eff;
      end else begin
        cnt_d = cnt_inc[DIV_W-1:0];
        if (cnt_inc == half) begin
          clk_out_d = 1'b0;
        end
      end
    end
  end

  // Strobes reflect actual transitions only; during the first period after reset the
  // high-to-low point is reached while clk_out is already 0, which yields no fall.
  assign rise_d = clk_out_d & ~clk_out;
  assign fall_d = ~clk_out_d & clk_out;
  assign load   = rise_d | (EDGE_MODE & fall_d);

  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = (ptr_q == LastChan) ? '0 : ptr_q + SelW'(1);
    end
  end

  // Explicit compare mux keeps the selection in range for non-power-of-two channel counts.
  always_comb begin
    chan_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (ptr_q == SelW'(k)) begin
        chan_data = data_in[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      n_eff_q   <= ratio_eff;
      clk_out   <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      ptr_q     <= '0;
      out       <= '0;
      chan_sel  <= '0;
      out_valid <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      n_eff_q   <= n_eff_d;
      clk_out   <= clk_out_d;
      rise_tick <= rise_d;
      fall_tick <= fall_d;
      ptr_q     <= ptr_d;
      out_valid <= load;
      if (load) begin
        out      <= chan_data;
        chan_sel <= ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_tdm.sv
// Self-checking bench for clk_div_tdm. Two instances run side by side on shared control:
// dut0 (EDGE_MODE=0, CHANNELS=2) and dut1 (EDGE_MODE=1, CHANNELS=4). Every cycle both are
// compared against a period-position reference model; directed sequences add explicit checks.
module tb_clk_div_tdm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  div_ratio = 8'd2;
  logic [15:0] data0 = '0;
  logic [31:0] data1 = '0;

  logic        clk_out0, rise0, fall0, valid0;
  logic [7:0]  out0;
  logic [0:0]  sel0;
  logic        clk_out1, rise1, fall1, valid1;
  logic [7:0]  out1;
  logic [1:0]  sel1;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  clk_div_tdm #(.DATA_W(8), .CHANNELS(2), .DIV_W(8), .EDGE_MODE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .div_ratio(div_ratio), .data_in(data0),
    .clk_out(clk_out0), .rise_tick(rise0), .fall_tick(fall0), .out(out0),
    .chan_sel(sel0), .out_valid(valid0)
  );

  clk_div_tdm #(.DATA_W(8), .CHANNELS(4), .DIV_W(8), .EDGE_MODE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .div_ratio(div_ratio), .data_in(data1),
    .clk_out(clk_out1), .rise_tick(rise1), .fall_tick(fall1), .out(out1),
    .chan_sel(sel1), .out_valid(valid1)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: position within the current period, counted in enabled cycles.
  // A period starts with a rise; clk_out is high for the first ceil(N/2) cycles of it.
  int   m_e[2], m_start[2], m_n[2], m_ptr[2], m_sel[2];
  bit   m_first[2], m_clk[2], m_rise[2], m_fall[2], m_valid[2];
  logic [7:0] m_out[2];

  function automatic int eff_ratio(input int r);
    return (r < 2) ? 2 : r;
  endfunction

  task automatic model_step(input int m, input bit em, input int nch, input logic [31:0] d);
    int t;
    bit nclk;
    logic [31:0] dd;
    if (reset) begin
      m_e[m] = 0; m_start[m] = 0; m_n[m] = eff_ratio(int'(div_ratio)); m_first[m] = 1;
      m_clk[m] = 0; m_rise[m] = 0; m_fall[m] = 0; m_valid[m] = 0;
      m_out[m] = 8'h00; m_sel[m] = 0; m_ptr[m] = 0;
    end else if (enable) begin
      m_e[m]++;
      t = m_e[m] - m_start[m];
      if (t == m_n[m]) begin
        m_start[m] = m_e[m];
        m_n[m] = eff_ratio(int'(div_ratio));
        m_first[m] = 0;
        nclk = 1;
      end else begin
        nclk = m_first[m] ? 1'b0 : (t < (m_n[m] + 1) / 2);
      end
      m_rise[m] = nclk && !m_clk[m];
      m_fall[m] = !nclk && m_clk[m];
      m_valid[m] = m_rise[m] || (em && m_fall[m]);
      if (m_valid[m]) begin
        dd = d >> (8 * m_ptr[m]);
        m_out[m] = dd[7:0];
        m_sel[m] = m_ptr[m];
        m_ptr[m] = (m_ptr[m] + 1) % nch;
      end
      m_clk[m] = nclk;
    end else begin
      m_rise[m] = 0; m_fall[m] = 0; m_valid[m] = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_model();
    chk("d0 clk_out",   32'(clk_out0), 32'(m_clk[0]));
    chk("d0 rise_tick", 32'(rise0),    32'(m_rise[0]));
    chk("d0 fall_tick", 32'(fall0),    32'(m_fall[0]));
    chk("d0 out",       32'(out0),     32'(m_out[0]));
    chk("d0 chan_sel",  32'(sel0),     32'(m_sel[0]));
    chk("d0 out_valid", 32'(valid0),   32'(m_valid[0]));
    chk("d1 clk_out",   32'(clk_out1), 32'(m_clk[1]));
    chk("d1 rise_tick", 32'(rise1),    32'(m_rise[1]));
    chk("d1 fall_tick", 32'(fall1),    32'(m_fall[1]));
    chk("d1 out",       32'(out1),     32'(m_out[1]));
    chk("d1 chan_sel",  32'(sel1),     32'(m_sel[1]));
    chk("d1 out_valid", 32'(valid1),   32'(m_valid[1]));
  endtask

  task automatic cycle(input logic en, input logic rst, input logic [7:0] ratio);
    enable = en;
    reset = rst;
    div_ratio = ratio;
    @(posedge clk);
    cyc++;
    model_step(0, 1'b0, 2, {16'h0, data0});
    model_step(1, 1'b1, 4, data1);
    #1;
    check_model();
  endtask

  typedef struct {
    logic       en;
    logic       clk_o;
    logic       rise;
    logic       fall;
    logic [7:0] out;
    logic       sel;
    logic       valid;
  } vec_t;

  vec_t tbl[10];
  int   rises[$];
  int   exp_r[4];
  int   first_rise;
  logic [7:0] exp_out[5];

  initial begin
    // N=3 on dut0: pattern 1,1,0 after the first rise, A1/B2 alternating, one stall row.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hA1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hB2, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hB2, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hB2, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b1};

    // Reset with N=4: outputs zero, first rise on the 4th enabled cycle, period 4.
    data0 = 16'hB2A1;
    data1 = 32'h40302010;
    cycle(1'b1, 1'b1, 8'd4);
    cycle(1'b1, 1'b1, 8'd4);
    chk("reset clk_out", 32'(clk_out0), 32'd0);
    chk("reset out", 32'(out0), 32'd0);
    chk("reset out_valid", 32'(valid0), 32'd0);
    rises.delete();
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 1'b0, 8'd4);
      if (rise0) rises.push_back(i);
    end
    first_rise = (rises.size() > 0) ? rises[0] : -1;
    chk("first rise cycle", 32'(first_rise), 32'd4);
    chk("second rise cycle", 32'((rises.size() > 1) ? rises[1] : -1), 32'd8);

    // Table-driven N=3 sequence.
    cycle(1'b1, 1'b1, 8'd3);
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].en, 1'b0, 8'd3);
      chk("tbl clk_out", 32'(clk_out0), 32'(tbl[i].clk_o));
      chk("tbl rise", 32'(rise0), 32'(tbl[i].rise));
      chk("tbl fall", 32'(fall0), 32'(tbl[i].fall));
      chk("tbl out", 32'(out0), 32'(tbl[i].out));
      chk("tbl chan_sel", 32'(sel0), 32'(tbl[i].sel));
      chk("tbl out_valid", 32'(valid0), 32'(tbl[i].valid));
    end

    // EDGE_MODE=1, 4 channels, N=2: one load per cycle after the first rise.
    exp_out = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
    cycle(1'b1, 1'b1, 8'd2);
    cycle(1'b1, 1'b0, 8'd2);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 8'd2);
      chk("edge2 out", 32'(out1), 32'(exp_out[i]));
      chk("edge2 out_valid", 32'(valid1), 32'd1);
    end

    // Ratio change 6 -> 2 at cnt=2: current period still 6, then periods of 2.
    exp_r = '{6, 12, 14, 16};
    cycle(1'b1, 1'b1, 8'd6);
    cycle(1'b1, 1'b1, 8'd6);
    rises.delete();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b0, (i >= 9) ? 8'd2 : 8'd6);
      if (rise0) rises.push_back(i);
    end
    for (int k = 0; k < 4; k++) begin
      chk("ratio change rise", 32'((k < rises.size()) ? rises[k] : -1), 32'(exp_r[k]));
    end
    chk("ratio change count", 32'(rises.size()), 32'd4);

    // Ratio 0 and 1 behave as 2.
    cycle(1'b1, 1'b1, 8'd0);
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 8'd1);
    chk("ratio1 clk_out", 32'(clk_out0), 32'd1);
    cycle(1'b1, 1'b0, 8'd1);
    chk("ratio1 fall", 32'(fall0), 32'd1);

    // Stall 5 cycles mid-high with N=6, then the high phase finishes normally.
    cycle(1'b1, 1'b1, 8'd6);
    for (int i = 1; i <= 7; i++) cycle(1'b1, 1'b0, 8'd6);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 8'd6);
      chk("stall clk_out", 32'(clk_out0), 32'd1);
      chk("stall ticks", 32'({rise0, fall0, valid0}), 32'd0);
    end
    cycle(1'b1, 1'b0, 8'd6);
    chk("resume hold", 32'({clk_out0, fall0}), 32'b10);
    cycle(1'b1, 1'b0, 8'd6);
    chk("resume fall", 32'({clk_out0, fall0}), 32'b01);
    cycle(1'b1, 1'b0, 8'd6);
    cycle(1'b1, 1'b0, 8'd6);
    cycle(1'b1, 1'b0, 8'd6);
    chk("resume rise", 32'(rise0), 32'd1);

    // Reset in the low phase with dut1 pointer at 2; first load afterwards is channel 0.
    cycle(1'b1, 1'b1, 8'd4);
    for (int i = 1; i <= 6; i++) cycle(1'b1, 1'b0, 8'd4);
    chk("pre-reset d1 sel", 32'(sel1), 32'd1);
    cycle(1'b1, 1'b1, 8'd4);
    chk("mid reset d1", 32'({clk_out1, rise1, fall1, valid1, sel1, out1}), 32'd0);
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 8'd4);
    chk("post reset d1 out", 32'(out1), 32'h10);
    chk("post reset d1 valid", 32'({valid1, sel1}), 32'b100);

    // Randomised run against the model.
    for (int i = 0; i < 400; i++) begin
      data0 = 16'($urandom);
      data1 = $urandom;
      cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 9)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
